// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus whole-vector debouncer for the data/select switches.
// A new value commits only after STABLE_CYCLES identical synchronized samples.
module switch_debouncer_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_ff1, r_ff2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff1 <= 1'b0;
      r_ff2 <= 1'b0;
    end else begin
      r_ff1 <= i_d;
      r_ff2 <= r_ff1;
    end
  end

  assign o_q = r_ff2;
endmodule

module switch_debouncer #(
  parameter int DATA_W        = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_select,
  output logic [DATA_W-1:0] data,
  output logic              select,
  output logic              changed,
  output logic              busy
);
  localparam int VW = DATA_W + 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  state_t          r_state, w_state_nxt;
  logic [VW-1:0]   w_raw, w_sync;
  logic [VW-1:0]   r_cand, w_cand_nxt, r_commit;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_changed, w_commit;

  assign w_raw = {sw_select, sw_data};

  genvar g;
  generate
    for (g = 0; g < VW; g++) begin : g_sync
      switch_debouncer_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_raw[g]),
        .o_q   (w_sync[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Any bit differing from the candidate restarts qualification of the whole vector.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sync != r_commit) begin
          w_cand_nxt  = w_sync;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_COUNT;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      S_COUNT: begin
        if (w_sync != r_cand) begin
          if (w_sync == r_commit) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cand_nxt  = w_sync;
            w_cnt_nxt   = CW'(1);
          end
        end else if (r_cnt == CW'(STABLE_CYCLES - 1)) begin
          w_commit    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_COUNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand    <= '0;
      r_cnt     <= '0;
      r_commit  <= '0;
      r_changed <= 1'b0;
    end else begin
      r_cand    <= w_cand_nxt;
      r_cnt     <= w_cnt_nxt;
      r_commit  <= w_commit ? r_cand : r_commit;
      r_changed <= w_commit;
    end
  end

  assign data    = r_commit[DATA_W-1:0];
  assign select  = r_commit[DATA_W];
  assign changed = r_changed;
endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CYCLES=4 (commit at edge 5 after a raw change).
module tb_switch_debouncer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_data;
  logic       sw_select;
  logic [3:0] data;
  logic       select, changed, busy;

  int vec = 0;
  int err = 0;
  int npulse, nbusy, saw2;

  switch_debouncer #(.DATA_W(4), .STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_data   (sw_data),
    .sw_select (sw_select),
    .data      (data),
    .select    (select),
    .changed   (changed),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps n edges, tallying changed pulses, busy cycles and any appearance of data==2.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (changed) npulse++;
      if (busy) nbusy++;
      if (data == 4'h2) saw2++;
    end
  endtask

  task automatic clr();
    npulse = 0; nbusy = 0; saw2 = 0;
  endtask

  initial begin
    clr();
    // Reset with inputs held at A/1
    rst_n = 1'b0; sw_data = 4'hA; sw_select = 1'b1;
    step(); step();
    chk("rst_data",    {4'h0, data}, 8'h00);
    chk("rst_select",  {7'h0, select}, 8'h00);
    chk("rst_changed", {7'h0, changed}, 8'h00);
    chk("rst_busy",    {7'h0, busy}, 8'h00);
    rst_n = 1'b1;
    clr(); run(5);
    chk("rel_nocommit_e4", {4'h0, data}, 8'h00);
    chk("rel_busy_e4",     {7'h0, busy}, 8'h01);
    run(1);
    chk("rel_data_e5",   {4'h0, data}, 8'h0A);
    chk("rel_select_e5", {7'h0, select}, 8'h01);
    chk("rel_pulse_e5",  {7'h0, changed}, 8'h01);
    run(4);
    chk("rel_one_pulse", npulse[7:0], 8'd1);

    // Re-reset with zero inputs: no commit afterwards
    rst_n = 1'b0; sw_data = 4'h0; sw_select = 1'b0;
    step();
    rst_n = 1'b1;
    clr(); run(8);
    chk("zero_nopulse", npulse[7:0], 8'd0);
    chk("zero_nobusy",  nbusy[7:0], 8'd0);

    // Clean step 0 -> 5
    sw_data = 4'h5;
    clr(); run(2);
    chk("step_busy_e1", {7'h0, busy}, 8'h00);
    run(1);
    chk("step_busy_e2", {7'h0, busy}, 8'h01);
    run(2);
    chk("step_data_e4", {4'h0, data}, 8'h00);
    run(1);
    chk("step_data_e5",  {4'h0, data}, 8'h05);
    chk("step_pulse_e5", {7'h0, changed}, 8'h01);
    chk("step_busy_e5",  {7'h0, busy}, 8'h00);
    run(1);
    chk("step_pulse_e6", {7'h0, changed}, 8'h00);

    // Bounce on bit 0 from committed 0
    rst_n = 1'b0; sw_data = 4'h0;
    step();
    rst_n = 1'b1;
    run(4);
    clr();
    for (int k = 0; k < 10; k++) begin
      sw_data = (k % 2 == 0) ? 4'h1 : 4'h0;
      run(2);
    end
    chk("bounce_nopulse", npulse[7:0], 8'd0);
    chk("bounce_data",    {4'h0, data}, 8'h00);
    sw_data = 4'h1;
    clr(); run(5);
    chk("bounce_data_e4", {4'h0, data}, 8'h00);
    run(1);
    chk("bounce_data_e5",  {4'h0, data}, 8'h01);
    chk("bounce_pulse_e5", {7'h0, changed}, 8'h01);

    // Short glitch 3 -> 7 for 3 cycles
    sw_data = 4'h3;
    run(10);
    chk("glitch_pre", {4'h0, data}, 8'h03);
    sw_data = 4'h7;
    clr(); run(3);
    sw_data = 4'h3;
    run(10);
    chk("glitch_busy_seen", {7'h0, (nbusy > 0)}, 8'h01);
    chk("glitch_nopulse",   npulse[7:0], 8'd0);
    chk("glitch_data",      {4'h0, data}, 8'h03);

    // Restart: 2 for 3 cycles then 6
    sw_data = 4'h0;
    run(10);
    chk("restart_pre", {4'h0, data}, 8'h00);
    sw_data = 4'h2;
    clr(); run(3);
    sw_data = 4'h6;
    run(12);
    chk("restart_data",   {4'h0, data}, 8'h06);
    chk("restart_pulses", npulse[7:0], 8'd1);
    chk("restart_no2",    saw2[7:0], 8'd0);

    // Mid-count reset with raw F
    sw_data = 4'hF;
    run(4);
    chk("mid_busy", {7'h0, busy}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("mid_data_clr",   {4'h0, data}, 8'h00);
    chk("mid_busy_clr",   {7'h0, busy}, 8'h00);
    chk("mid_changed",    {7'h0, changed}, 8'h00);
    step();
    rst_n = 1'b1;
    clr(); run(5);
    chk("mid_e4_data",  {4'h0, data}, 8'h00);
    chk("mid_e4_pulse", npulse[7:0], 8'd0);
    run(1);
    chk("mid_e5_data",  {4'h0, data}, 8'h0F);
    chk("mid_e5_pulse", {7'h0, changed}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
